// File: rtl/mem_burst_reader.sv
// Burst read master: streams Len words from StartAddr out of a 1-cycle-latency memory port.
// Optional MEM_BURST_READER_LAST_EN adds Out_Last, flagging the final word of each burst.
module mem_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] StartAddr,
  input  logic [ADDR_WIDTH:0]   Len,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Mem_WE,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  input  logic [DATA_WIDTH-1:0] Mem_RdData,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Out_Valid,
`ifdef MEM_BURST_READER_LAST_EN
  output logic                  Out_Last,
`endif
  input  logic                  Out_Ready,
  output logic [1:0]            Dbg_State
);

  // Stream handshake: a word moves when Out_Valid && Out_Ready at posedge Clk;
  // Out_Valid comes from registered buffer occupancy only, and the head word
  // (data and last flag) stays put until that handshake.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     issue_left_q, issue_left_d;
  logic [ADDR_WIDTH:0]     deliver_left_q, deliver_left_d;
  logic                    done_q, done_d;
  logic                    infl1_q, infl2_q;
  logic [DATA_WIDTH-1:0]   buf_data_q [4];
  logic [1:0]              wr_ptr_q, rd_ptr_q;
  logic [2:0]              count_q, count_d;
  logic                    issue, push, pop;

  assign push = infl2_q;
  assign pop  = (count_q != '0) && Out_Ready;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    issue_left_d   = issue_left_q;
    deliver_left_d = deliver_left_q;
    done_d         = 1'b0;
    issue          = 1'b0;
    if (pop) deliver_left_d = deliver_left_q - LEN_ONE;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Len == '0) begin
            done_d = 1'b1;
          end else begin
            // The first read goes out on the edge that enters RUN, giving the 2-cycle start latency.
            issue          = 1'b1;
            addr_d         = StartAddr;
            issue_left_d   = Len - LEN_ONE;
            deliver_left_d = Len;
            state_d        = (Len == LEN_ONE) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (({1'b0, count_q} + {3'b000, infl1_q} + {3'b000, infl2_q}) < 4'd4) begin
          issue        = 1'b1;
          addr_d       = addr_q + ADDR_ONE;
          issue_left_d = issue_left_q - LEN_ONE;
          if (issue_left_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (deliver_left_q == LEN_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      done_q         <= 1'b0;
      infl1_q        <= 1'b0;
      infl2_q        <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      for (int i = 0; i < 4; i++) buf_data_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      issue_left_q   <= issue_left_d;
      deliver_left_q <= deliver_left_d;
      done_q         <= done_d;
      infl1_q        <= issue;
      infl2_q        <= infl1_q;
      count_q        <= count_d;
      if (push) begin
        buf_data_q[wr_ptr_q] <= Mem_RdData;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

`ifdef MEM_BURST_READER_LAST_EN
  logic       last1_q, last2_q;
  logic [3:0] buf_last_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      last1_q    <= 1'b0;
      last2_q    <= 1'b0;
      buf_last_q <= '0;
    end else begin
      last1_q <= issue && ((state_q == IDLE) ? (Len == LEN_ONE) : (issue_left_q == LEN_ONE));
      last2_q <= last1_q;
      if (push) buf_last_q[wr_ptr_q] <= last2_q;
    end
  end

  // Gated with valid so a stale flag in an emptied slot never shows.
  assign Out_Last = Out_Valid && buf_last_q[rd_ptr_q];
`endif

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign Mem_WE    = 1'b0;
  assign Mem_Addr  = addr_q;
  assign Out_Valid = (count_q != '0);
  assign Out_Data  = buf_data_q[rd_ptr_q];
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: registered-read memory model, burst-level queue model, per-cycle compare.
// Define MEM_BURST_READER_LAST_EN for the Out_Last checks.
module tb_mem_burst_reader;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, mem_we, out_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd = '0;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic [1:0]    dbg_state;
`ifdef MEM_BURST_READER_LAST_EN
  logic          out_last;
`endif

  mem_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .StartAddr(start_addr), .Len(len),
    .Busy(busy), .Done(done), .Mem_WE(mem_we), .Mem_Addr(mem_addr),
    .Mem_RdData(mem_rd), .Out_Data(out_data), .Out_Valid(out_valid),
`ifdef MEM_BURST_READER_LAST_EN
    .Out_Last(out_last),
`endif
    .Out_Ready(out_ready), .Dbg_State(dbg_state)
  );

  // ---------------- clock / memory / ready driver ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) mem_rd <= mem[mem_addr];

  int ready_mode = 0;   // 0: always 1, 1: fixed pattern, 2: random, 3: always 0
  int pat_idx = 0;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = pat[pat_idx]; pat_idx = (pat_idx + 1) % 7; end
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  bit            gotl_q [$];
  logic          busy_exp = 1'b0;
  logic          done_exp = 1'b0;
  logic          done_next;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  logic [AW-1:0] burst_start = '0;
  logic [AW-1:0] lead;
  int            acc = 0;
  int            done_cnt = 0;
  logic [DW-1:0] e;
  logic          cur_last;

  // Model: a burst is the list mem[start..start+len-1] (mod depth), consumed in order on
  // handshakes; Busy spans accept..last handshake, Done is the cycle after the last handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy_exp   = 1'b0;
      done_exp   = 1'b0;
      stall_prev = 1'b0;
    end else begin
`ifdef MEM_BURST_READER_LAST_EN
      cur_last = out_last;
`else
      cur_last = 1'b0;
`endif
      check(mem_we == 1'b0, "mem_we", mem_we, 0);
      check(busy == busy_exp, "busy", busy, busy_exp);
      check(done == done_exp, "done", done, done_exp);
      if (done) done_cnt++;
      if (stall_prev) begin
        check(out_valid == 1'b1, "hold_valid", out_valid, 1);
        check(out_data == held_data, "hold_data", out_data, held_data);
        check(cur_last == held_last, "hold_last", cur_last, held_last);
      end
      if (out_valid && exp_q.size() == 0) check(1'b0, "extra_word", out_data, 0);
      if (!out_valid) check(cur_last == 1'b0, "last_idle", cur_last, 0);
      if (busy_exp) begin
        lead = mem_addr - burst_start - acc[AW-1:0];
        check(lead <= 3, "lead", lead + 1, 4);
      end
      done_next = 1'b0;
      if (start && !busy_exp) begin
        if (len == '0) begin
          done_next = 1'b1;
        end else begin
          got_q.delete();
          gotl_q.delete();
          for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[AW'(int'(start_addr) + i)]);
          busy_exp    = 1'b1;
          burst_start = start_addr;
          acc         = 0;
        end
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(out_data == e, "data", out_data, e);
`ifdef MEM_BURST_READER_LAST_EN
        check(out_last == (exp_q.size() == 0), "last", out_last, exp_q.size() == 0);
`endif
        got_q.push_back(out_data);
        gotl_q.push_back(cur_last);
        acc++;
        if (exp_q.size() == 0) begin
          done_next = 1'b1;
          busy_exp  = 1'b0;
        end
      end
      done_exp   = done_next;
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = cur_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int a, input int l);
    start      = 1'b1;
    start_addr = AW'(a);
    len        = (AW + 1)'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy_exp || exp_q.size() != 0) && c < 6000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 6000) check(1'b0, "timeout", c, 6000);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int base;
  int wseq [4] = '{1022, 1023, 0, 1};
  int wdat [4] = '{1122, 1123, 100, 101};

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
    repeat (3) @(posedge clk);
    #2;
    check(busy == 1'b0 && done == 1'b0 && out_valid == 1'b0, "rst_flags", {busy, done, out_valid}, 0);
    check(mem_addr == '0, "rst_addr", mem_addr, 0);
    check(out_data == '0, "rst_data", out_data, 0);
    check(dbg_state == 2'd0, "rst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic burst, ready held high: exact latency and data.
    ready_mode = 0;
    pulse_start(5, 4);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) check(mem_addr == 10'd5, "t1_addr", mem_addr, 5);
      check(out_valid == (k >= 2 && k <= 5), "t1_valid", out_valid, k >= 2 && k <= 5);
      if (k >= 2 && k <= 5) check(out_data == DW'(103 + k), "t1_data", out_data, 103 + k);
      if (k == 6) check(done == 1'b1 && busy == 1'b0, "t1_done", {done, busy}, 2);
    end
    wait_idle();

    // Same burst under the toggling ready pattern.
    pat_idx = 0;
    ready_mode = 1;
    pulse_start(5, 4);
    wait_idle();
    check(got_q.size() == 4, "t2_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check(got_q[i] == DW'(105 + i), "t2_word", got_q[i], 105 + i);

    // Address wrap.
    ready_mode = 0;
    pulse_start(1022, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check(int'(mem_addr) == wseq[k], "wrap_addr", mem_addr, wseq[k]);
    end
    wait_idle();
    check(got_q.size() == 4, "wrap_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check(got_q[i] == DW'(wdat[i]), "wrap_word", got_q[i], wdat[i]);

    // Zero length.
    base = done_cnt;
    pulse_start(7, 0);
    wait_idle();
    check(done_cnt - base == 1, "len0_done", done_cnt - base, 1);

    // Start during a burst is ignored.
    base = done_cnt;
    pulse_start(0, 8);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(50, 3);
    wait_idle();
    check(got_q.size() == 8, "ign_count", got_q.size(), 8);
    check(done_cnt - base == 1, "ign_done", done_cnt - base, 1);

    // Reset with 2 words buffered and 2 in flight.
    base = done_cnt;
    ready_mode = 3;
    pulse_start(20, 8);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check(out_valid == 1'b0 && busy == 1'b0, "midrst", {out_valid, busy}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check(done_cnt == base, "midrst_nodone", done_cnt - base, 0);
    pulse_start(0, 2);
    wait_idle();
    check(got_q.size() == 2, "post_rst_count", got_q.size(), 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++)
      check(got_q[i] == DW'(100 + i), "post_rst_word", got_q[i], 100 + i);

    // Randomized bursts over random memory contents.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int b = 0; b < 30; b++) begin
      ready_mode = $urandom_range(0, 2);
      pulse_start($urandom_range(0, DEPTH - 1), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 14));
      wait_idle();
    end
    ready_mode = 2;
    pulse_start($urandom_range(0, DEPTH - 1), DEPTH);
    wait_idle();
    check(got_q.size() == DEPTH, "full_count", got_q.size(), DEPTH);

`ifdef MEM_BURST_READER_LAST_EN
    ready_mode = 2;
    pulse_start(300, 3);
    wait_idle();
    check(gotl_q.size() == 3, "last_count", gotl_q.size(), 3);
    for (int i = 0; i < 3 && i < gotl_q.size(); i++)
      check(gotl_q[i] == (i == 2), "last_flag", gotl_q[i], i == 2);
    check(out_last == 1'b0, "last_after_done", out_last, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side master for one port of sync_dual_mem: given a start address and length, issues sequential reads on a memory port and streams the returned words out over a valid/ready interface.
- Absorbs the memory's 1-cycle registered read latency and downstream backpressure with an internal 4-entry buffer.
- Typical use: port B of sync_dual_mem drains a frame that another agent wrote through port A.

Parameters:
DATA_WIDTH, 32, width of a memory word and of Out_Data
ADDR_WIDTH, 10, memory address width; memory depth is 1<<ADDR_WIDTH

Ports:
Clk  input  1  clock; all logic on posedge
Rst  input  1  asynchronous, active-high reset
Start  input  1  one-cycle request; accepted only in IDLE
StartAddr  input  ADDR_WIDTH  first word address, sampled with Start
Len  input  ADDR_WIDTH+1  word count, sampled with Start; 0 to 1<<ADDR_WIDTH
Busy  output  1  high from the accepted Start until Done
Done  output  1  one-cycle pulse after the last word is handed off
Mem_WE  output  1  write enable to memory port; constant 0
Mem_Addr  output  ADDR_WIDTH  registered read address to memory port
Mem_RdData  input  DATA_WIDTH  memory read data, valid the cycle after the memory samples Mem_Addr
Out_Data  output  DATA_WIDTH  stream data
Out_Valid  output  1  stream valid
Out_Ready  input  1  stream ready from consumer

Behaviour:
- Reset (async assert, sync release) forces the following values:
  - state IDLE; Busy=0, Done=0, Out_Valid=0, Mem_Addr=0, Out_Data=0, Mem_WE=0.
  - Buffer, in-flight tags and counters cleared.
- States are IDLE, RUN and DRAIN.
  - IDLE: Start=1 with Len>0 latches StartAddr and Len, then goes to RUN with Busy=1.
  - IDLE: Start=1 with Len=0 stays in IDLE, issues no reads and pulses Done on the next cycle. Busy stays 0.
  - RUN: issues reads. When the last address has been issued, go to DRAIN.
  - DRAIN: when the last word is accepted (Out_Valid&&Out_Ready), return to IDLE. Done=1 for exactly one cycle on that transition and Busy drops in the same cycle.
- Start is ignored while Busy=1.
- Issue rule:
  - A read is issued in a cycle only if buffer occupancy plus reads in flight (at most 2: registered address stage, memory stage) is less than 4.
  - Each issue loads Mem_Addr with the next address.
  - The address increments modulo 1<<ADDR_WIDTH, so wrap from 2^ADDR_WIDTH-1 to 0 is legal.
- Latency: with Start sampled at edge 0, Mem_Addr=StartAddr after edge 0 and the memory samples it at edge 1. The word enters the buffer at edge 2, so Out_Valid=1 after edge 2.
- Throughput: with Out_Ready held at 1, one word per cycle is sustained.
  - An N-word burst shows N consecutive Out_Valid cycles.
  - Done follows the last handshake.
- Stream rules:
  - Once Out_Valid=1, Out_Data is held stable until accepted.
  - Words are delivered in address order, with no loss or duplication under any Out_Ready pattern.
  - Out_Valid never depends combinationally on Out_Ready.
- Mem_Addr holds its last value when no read is issued. No read is issued outside RUN.
- Len=1<<ADDR_WIDTH reads the whole memory exactly once, wrapping back toward StartAddr.
- Rst asserted mid-burst drops the burst immediately.
  - Outstanding data is discarded and no Done is produced.
  - After release the block is in IDLE.

Optional Feature:
- Macro: MEM_BURST_READER_LAST_EN.
- When defined:
  - Adds output port Out_Last (1 bit), high together with Out_Valid on the final word of a burst.
  - Out_Last is held stable with Out_Data and resets to 0.
  - It is carried through the buffer alongside the data.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Memory preloaded with mem[i]=i+100. Start with StartAddr=5, Len=4, Out_Ready=1:
  - Out_Valid is high for edges 2-5 with Out_Data 105, 106, 107, 108.
  - Done pulses once, Busy falls, and Mem_WE is 0 throughout.
- Same burst with Out_Ready toggling 1,0,0,1,0,1,1…:
  - Stream delivers 105..108 in order, with Out_Data stable while stalled.
  - Mem_Addr never runs more than 4 words ahead of the last accepted word.
- StartAddr=1022, Len=4, ADDR_WIDTH=10: Mem_Addr sequence is 1022, 1023, 0, 1; Out_Data is 1122, 1123, 100, 101.
- Start with Len=0: Done pulses the next cycle, Busy stays 0, Out_Valid stays 0. A second Start asserted during a Len=8 burst is ignored, so exactly 8 words and one Done result.
- Rst pulsed while 2 words are buffered and 2 are in flight:
  - Out_Valid=0 and Busy=0 immediately, with no Done.
  - A new Start with StartAddr=0, Len=2 then returns 100, 101.
- With MEM_BURST_READER_LAST_EN defined, a Len=3 burst under random Out_Ready: Out_Last=1 only on the third accepted word, and Out_Last=0 after Done.
